// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl
//   Synchronous FIFO controller in front of one RAM32M used as 32x6 storage.
//   Ports A/B/C share the read address (rd_ptr) and return the three 2-bit
//   slices of a word; port D is the write address and carries no data.
//   A one-entry registered output stage sits after the RAM, giving a total
//   capacity of 33 entries.
//
// Ports
//   WCLK, RSTN           clock, asynchronous active-low reset
//   flush                synchronous clear of pointers, counts and output stage
//   s_valid/s_ready/s_data   upstream stream (s_ready registered)
//   m_valid/m_ready/m_data   downstream stream (all outputs registered)
//   count, almost_full   occupancy 0..33 and count >= AFULL_THRESH
//   ADDRA..ADDRD, DIA..DID, WE   RAM32M address/data/write-enable
//   DOA, DOB, DOC        asynchronous RAM read data at rd_ptr
module lutram_fifo_ctrl #(
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic       WCLK,
  input  logic       RSTN,
  input  logic       flush,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [5:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [5:0] m_data,
  output logic [5:0] count,
  output logic       almost_full,
  output logic [4:0] ADDRA,
  output logic [4:0] ADDRB,
  output logic [4:0] ADDRC,
  output logic [4:0] ADDRD,
  output logic [1:0] DIA,
  output logic [1:0] DIB,
  output logic [1:0] DIC,
  output logic [1:0] DID,
  output logic       WE,
  input  logic [1:0] DOA,
  input  logic [1:0] DOB,
  input  logic [1:0] DOC
);

  localparam logic [5:0] AF_TH = 6'(AFULL_THRESH);

  // Output stage: EMPTY means m_valid=0, FULL means m_data holds a word.
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

  out_state_e state_q, state_d;
  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] ram_cnt_q, ram_cnt_d;
  logic [5:0] m_data_q, m_data_d;
  logic       s_ready_q, s_ready_d;
  logic       we, load;

  // s_ready is a registered flag, so a full RAM never accepts a write in the
  // same cycle as a load frees a slot; this keeps wr_ptr off rd_ptr.
  assign we   = s_valid & s_ready_q & ~flush;
  // A load needs a written RAM entry; a same-edge write is not bypassed.
  assign load = ~flush & (ram_cnt_q != 6'd0) & ((state_q == OUT_EMPTY) | m_ready);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    m_data_d  = m_data_q;
    s_ready_d = s_ready_q;
    if (flush) begin
      state_d   = OUT_EMPTY;
      wr_ptr_d  = 5'd0;
      rd_ptr_d  = 5'd0;
      ram_cnt_d = 6'd0;
      s_ready_d = 1'b1;
    end else begin
      if (we) wr_ptr_d = wr_ptr_q + 5'd1;
      if (load) begin
        rd_ptr_d = rd_ptr_q + 5'd1;
        m_data_d = {DOC, DOB, DOA};
        state_d  = OUT_FULL;
      end else if ((state_q == OUT_FULL) && m_ready) begin
        // Drained with nothing behind it; m_data keeps its last value.
        state_d = OUT_EMPTY;
      end
      ram_cnt_d = ram_cnt_q + {5'd0, we} - {5'd0, load};
      s_ready_d = (ram_cnt_d < 6'd32);
    end
  end

  always_ff @(posedge WCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= OUT_EMPTY;
      wr_ptr_q  <= 5'd0;
      rd_ptr_q  <= 5'd0;
      ram_cnt_q <= 6'd0;
      m_data_q  <= 6'h00;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = (state_q == OUT_FULL);
  assign m_data      = m_data_q;
  assign count       = ram_cnt_q + {5'd0, m_valid};
  assign almost_full = (count >= AF_TH);

  assign ADDRA = rd_ptr_q;
  assign ADDRB = rd_ptr_q;
  assign ADDRC = rd_ptr_q;
  assign ADDRD = wr_ptr_q;
  assign DIA   = s_data[1:0];
  assign DIB   = s_data[3:2];
  assign DIC   = s_data[5:4];
  assign DID   = 2'b00;
  assign WE    = we;

endmodule
